// File: rtl/or_reduce_pkg.sv
// Constant helpers shared by the pipelined OR reducer: tree depth, per-level
// widths and bit offsets into the flattened tree bus, index width.
package or_reduce_pkg;

   // Capture-register update selected by sticky_en / clear.
   typedef enum logic [1:0] {
      CAP_TRACK = 2'd0,
      CAP_ACCUM = 2'd1,
      CAP_CLEAR = 2'd2
   } cap_mode_e;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // Smallest k with fan_in**k >= n; 0 for a single input.
   function automatic int levels_for(input int n, input int fan_in);
      int k;
      int span;
      k    = 0;
      span = 1;
      while (span < n) begin
         span = span * fan_in;
         k    = k + 1;
      end
      return k;
   endfunction

   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Width of tree level lvl; level 0 is the capture vector itself.
   function automatic int level_width(input int n, input int fan_in, input int lvl);
      int w;
      w = n;
      for (int i = 0; i < lvl; i++) begin
         w = ceil_div(w, fan_in);
      end
      return w;
   endfunction

   // Bit offset of level lvl inside a bus holding levels 0..LEVELS back to back.
   function automatic int level_offset(input int n, input int fan_in, input int lvl);
      int off;
      off = 0;
      for (int i = 0; i < lvl; i++) begin
         off = off + level_width(n, fan_in, i);
      end
      return off;
   endfunction

endpackage

// File: rtl/or_tree_level.sv
// One registered level of the OR tree: groups of FAN_IN inputs, the last
// group zero-padded, each group ORed into one flop.
module or_tree_level
   import or_reduce_pkg::*;
#(
   parameter  int IN_W   = 8,
   parameter  int FAN_IN = 4,
   localparam int OUT_W  = ceil_div(IN_W, FAN_IN)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  d,
   output logic [OUT_W-1:0] q
);

   localparam int PAD_W = OUT_W * FAN_IN;

   logic [PAD_W-1:0] padded;
   logic [OUT_W-1:0] or_d;

   always_comb begin
      // NOTE: every variable assigned here gets a default first so no path can infer a latch.
      padded            = '0;
      or_d              = '0;
      padded[IN_W-1:0]  = d;
      for (int g = 0; g < OUT_W; g++) begin
         or_d[g] = |padded[g*FAN_IN +: FAN_IN];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else begin
         q <= or_d;
      end
   end

endmodule

// File: rtl/or_reduce_pipe.sv
// Pipelined N-to-1 OR reduction of synchronised flags with enable mask,
// sticky capture, rising-edge pulse and lowest-set-index aligned to out.
module or_reduce_pipe
   import or_reduce_pkg::*;
#(
   parameter  int NUM_INPUTS = 8,
   parameter  int FAN_IN     = 4,
   localparam int LEVELS     = levels_for(NUM_INPUTS, FAN_IN),
   localparam int IDX_W      = idx_width(NUM_INPUTS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_INPUTS-1:0] in_bits,
   input  logic [NUM_INPUTS-1:0] mask,
   input  logic                  sticky_en,
   input  logic                  clear,
   output logic                  out,
   output logic                  out_rise,
   output logic [IDX_W-1:0]      first_idx
);

   // Levels 0..LEVELS packed back to back; the last level is one bit wide.
   localparam int TREE_W = level_offset(NUM_INPUTS, FAN_IN, LEVELS) + 1;

   cap_mode_e             cap_mode;
   logic [NUM_INPUTS-1:0] masked;
   logic [NUM_INPUTS-1:0] cap;
   logic [NUM_INPUTS-1:0] cap_d;
   logic [TREE_W-1:0]     tree_bus;
   logic [IDX_W-1:0]      idx_now;
   logic                  out_prev;

   assign masked = in_bits & mask;

   always_comb begin
      cap_mode = CAP_TRACK;
      if (sticky_en) begin
         cap_mode = clear ? CAP_CLEAR : CAP_ACCUM;
      end
   end

   // Clear beats any bit arriving in the same cycle.
   always_comb begin
      cap_d = masked;
      case (cap_mode)
         CAP_ACCUM: cap_d = cap | masked;
         CAP_CLEAR: cap_d = '0;
         default:   cap_d = masked;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap <= '0;
      end else begin
         // NOTE: non-blocking assignment so every register samples pre-edge values.
         cap <= cap_d;
      end
   end

   assign tree_bus[NUM_INPUTS-1:0] = cap;

   for (genvar l = 0; l < LEVELS; l++) begin : g_level
      localparam int W_IN  = level_width(NUM_INPUTS, FAN_IN, l);
      localparam int W_OUT = level_width(NUM_INPUTS, FAN_IN, l + 1);
      localparam int O_IN  = level_offset(NUM_INPUTS, FAN_IN, l);
      localparam int O_OUT = level_offset(NUM_INPUTS, FAN_IN, l + 1);

      or_tree_level #(
         .IN_W   (W_IN),
         .FAN_IN (FAN_IN)
      ) u_level (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (tree_bus[O_IN +: W_IN]),
         .q     (tree_bus[O_OUT +: W_OUT])
      );
   end

   assign out = tree_bus[TREE_W-1];

   // Lowest set index wins: scan downward so the last hit is the smallest.
   always_comb begin
      idx_now = '0;
      for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
         if (cap[i]) begin
            idx_now = IDX_W'(i);
         end
      end
   end

   if (LEVELS == 0) begin : g_idx_direct
      assign first_idx = idx_now;
   end else begin : g_idx_delay
      logic [IDX_W-1:0] idx_q [LEVELS];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            // NOTE: this small delay line is reset element by element so stale indices never surface after reset.
            for (int s = 0; s < LEVELS; s++) begin
               idx_q[s] <= '0;
            end
         end else begin
            idx_q[0] <= idx_now;
            for (int s = 1; s < LEVELS; s++) begin
               idx_q[s] <= idx_q[s-1];
            end
         end
      end

      assign first_idx = idx_q[LEVELS-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_prev <= 1'b0;
      end else begin
         out_prev <= out;
      end
   end

   assign out_rise = out & ~out_prev;

endmodule

// File: tb/tb_or_reduce_pipe.sv
// Directed bench for or_reduce_pipe (defaults N=8, FAN_IN=4): a queue-based
// model checked every cycle plus hand-computed literal expectations.
module tb_or_reduce_pipe;

   localparam int N    = 8;
   localparam int PIPE = 2;  // tree depth for 8 inputs at fan-in 4

   logic         clk;
   logic         rst_n;
   logic [N-1:0] in_bits;
   logic [N-1:0] mask;
   logic         sticky_en;
   logic         clear;
   logic         out;
   logic         out_rise;
   logic [2:0]   first_idx;

   int n_cmp  = 0;
   int n_fail = 0;

   or_reduce_pipe #(
      .NUM_INPUTS (N),
      .FAN_IN     (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_bits   (in_bits),
      .mask      (mask),
      .sticky_en (sticky_en),
      .clear     (clear),
      .out       (out),
      .out_rise  (out_rise),
      .first_idx (first_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int lowest(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) begin
         if (v[i]) return i;
      end
      return 0;
   endfunction

   // Model: captured vectors history; the oldest entry is what out shows now.
   logic [N-1:0] m_cap;
   logic [N-1:0] hist [$];
   logic         m_prev;

   function automatic void m_reset();
      m_cap  = '0;
      m_prev = 1'b0;
      hist.delete();
      for (int i = 0; i <= PIPE; i++) hist.push_back('0);
   endfunction

   initial m_reset();

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_reset();
      end else begin
         m_prev = |hist[0];
         if (!sticky_en)  m_cap = in_bits & mask;
         else if (clear)  m_cap = '0;
         else             m_cap = m_cap | (in_bits & mask);
         hist.push_back(m_cap);
         void'(hist.pop_front());
      end
   end

   always @(negedge clk) begin
      logic e_out;
      e_out = |hist[0];
      check("model_out", out, e_out);
      check("model_rise", out_rise, e_out & ~m_prev);
      check("model_idx", first_idx, lowest(hist[0]));
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_bits   = '0;
      mask      = 8'hFF;
      sticky_en = 1'b0;
      clear     = 1'b0;
      tick(2);
      check("reset_out", out, 0);
      check("reset_rise", out_rise, 0);
      check("reset_idx", first_idx, 0);
      rst_n = 1'b1;
      tick(4);
      check("idle_out", out, 0);

      // Single-cycle pulse, non-sticky
      in_bits = 8'b0010_1100;
      tick();
      in_bits = '0;
      check("pulse_e1", out, 0);
      tick();
      check("pulse_e2", out, 0);
      tick();
      check("pulse_out", out, 1);
      check("pulse_rise", out_rise, 1);
      check("pulse_idx", first_idx, 2);
      tick();
      check("pulse_fall", out, 0);
      check("pulse_rise_gone", out_rise, 0);
      tick(2);

      // Masked bit, then unmasked
      mask    = 8'b1111_0111;
      in_bits = 8'b0000_1000;
      tick(5);
      check("masked_out", out, 0);
      mask = 8'hFF;
      tick(2);
      check("unmask_e2", out, 0);
      tick();
      check("unmask_out", out, 1);
      check("unmask_idx", first_idx, 3);
      in_bits = '0;
      tick(4);
      check("unmask_drain", out, 0);

      // Sticky latch and clear
      sticky_en = 1'b1;
      in_bits   = 8'b1000_0000;
      tick();
      in_bits = '0;
      tick(2);
      check("sticky_out", out, 1);
      check("sticky_idx", first_idx, 7);
      tick(8);
      check("sticky_hold", out, 1);
      check("sticky_hold_idx", first_idx, 7);
      check("sticky_no_rise", out_rise, 0);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
      check("clear_e2", out, 1);
      tick();
      check("clear_out", out, 0);
      tick(2);

      // Clear wins over a same-cycle input bit
      clear   = 1'b1;
      in_bits = 8'b0000_0001;
      tick();
      clear   = 1'b0;
      in_bits = '0;
      tick(5);
      check("clear_wins", out, 0);

      // Dropping sticky_en releases latched bits at the next edge
      in_bits = 8'b0001_0000;
      tick();
      in_bits = '0;
      tick(3);
      check("release_pre", out, 1);
      check("release_pre_idx", first_idx, 4);
      sticky_en = 1'b0;
      tick(2);
      check("release_e2", out, 1);
      tick();
      check("release_out", out, 0);

      // Masked bit in sticky mode is not retroactively latched
      sticky_en = 1'b1;
      mask      = 8'b1111_1110;
      in_bits   = 8'b0000_0001;
      tick();
      mask    = 8'hFF;
      in_bits = '0;
      tick(4);
      check("no_retro", out, 0);
      sticky_en = 1'b0;
      tick();

      // Asynchronous reset while out is high
      in_bits = 8'hFF;
      tick(3);
      check("pre_reset_out", out, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_out", out, 0);
      check("async_rise", out_rise, 0);
      check("async_idx", first_idx, 0);
      tick();
      rst_n = 1'b1;
      tick(2);
      check("post_reset_e2", out, 0);
      tick();
      check("post_reset_out", out, 1);
      check("post_reset_rise", out_rise, 1);
      check("post_reset_idx", first_idx, 0);
      in_bits = '0;
      tick(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/or_reduce_pipe.md
Name: or_reduce_pipe

Overview:
Parametrised, pipelined N-to-1 OR reduction for aggregating synchronised status/event flags from many CDC channels into one flag.
- Generalises the combinational OR-reducer with:
  - a registered tree of configurable fan-in;
  - a per-input enable mask;
  - a runtime sticky (event-latch) mode with synchronous clear;
  - a rising-edge pulse output;
  - lowest-set-index reporting aligned to the output.
- Sits after the per-bit synchronisers in the destination domain.

Parameters:
- NUM_INPUTS, 8: number of input flags (>=1).
- FAN_IN, 4: inputs per OR node per tree level (>=2).
- LEVELS (derived, localparam): number of tree levels = smallest k with FAN_IN^k >= NUM_INPUTS; 0 when NUM_INPUTS=1.
- IDX_W (derived, localparam): max(1, clog2(NUM_INPUTS)).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_bits  in  NUM_INPUTS  flags, already synchronous to clk.
- mask  in  NUM_INPUTS  1 = input enabled, 0 = ignored.
- sticky_en  in  1  1 = latch set bits until clear.
- clear  in  1  synchronous clear of the sticky capture register.
- out  out  1  OR of masked (or latched) inputs, pipelined.
- out_rise  out  1  one-cycle pulse when out goes 0->1.
- first_idx  out  IDX_W  lowest index set in the captured vector; 0 when none set.

Behaviour:
- Reset (rst_n low, asynchronous): capture register, all tree registers, index pipeline, out, first_idx and out_prev clear to 0. out_rise is 0 during reset.
- Capture stage (stage 0), every clk edge:
  - sticky_en=0: cap <= in_bits & mask. clear is ignored.
  - sticky_en=1, clear=0: cap <= cap | (in_bits & mask).
  - sticky_en=1, clear=1: cap <= 0. Clear wins; input bits set in the same cycle are discarded.
  - A sticky_en change takes effect at the next capture edge. Dropping sticky_en releases latched bits at that edge.
  - Masked bits never enter cap. Unmasking a bit later does not retroactively set it.
- Tree:
  - Each level registers ceil(prev_width/FAN_IN) OR nodes.
  - A partial last group is zero-padded.
  - The final level is 1 bit wide and drives out.
- Latency: in_bits/mask -> out = 1 + LEVELS cycles. Defaults give 3 cycles; NUM_INPUTS=1 gives 1 cycle.
- first_idx:
  - A priority encoder (lowest index wins) on cap.
  - Delayed through LEVELS registers so it changes on the same cycle as out for the same capture.
  - Value is 0 when cap is all zero. Read it as valid only while out=1.
- out_rise = out & ~out_prev, where out_prev is a register of out. It is combinational from registers, so it is high in the first cycle out is 1.
- Clear does not flush the tree: out falls LEVELS+1 cycles after the clear edge, unless in_bits re-set cap.
- Reset mid-operation discards all in-flight data. The first post-reset out is valid 1+LEVELS cycles after the first capture.
- No combinational path from any input to any output.

Decomposition:
- Package or_reduce_pkg: constant functions levels_for(n, fan_in), ceil_div(a, b), idx_width(n). Used to derive LEVELS, per-level widths and IDX_W.
- Sub-module or_tree_level: one registered level.
  - Parameters IN_W, FAN_IN; output width ceil_div(IN_W, FAN_IN).
  - Zero-padded groups; asynchronous active-low reset.
- Top level instantiates LEVELS copies of or_tree_level via generate, plus the capture register, the index delay line and the edge detector.

Test Plan (defaults NUM_INPUTS=8, FAN_IN=4; latency 3):
- Reset then all zero, mask=8'hFF -> out=0, out_rise=0, first_idx=0 throughout.
- sticky_en=0, in_bits=8'b0010_1100 for 1 cycle at edge T -> out=1 at T+2 (3rd edge from apply) for exactly 1 cycle; out_rise pulses once; first_idx=2 in the same cycle.
- mask=8'b1111_0111, in_bits=8'b0000_1000 held -> out stays 0. Then mask=8'hFF -> out=1 three cycles later, first_idx=3.
- sticky_en=1, in_bits=8'b1000_0000 for 1 cycle then 0 -> out stays 1 indefinitely, first_idx=7. Pulse clear=1 for 1 cycle -> out=0 three cycles after the clear edge.
- sticky_en=1, clear=1 and in_bits=8'b0000_0001 in the same cycle -> bit discarded, out remains 0.
- Assert rst_n=0 asynchronously while out=1 mid-stream -> out, out_rise, first_idx go 0 immediately. After release with in_bits=8'hFF -> out=1 on the 3rd edge, first_idx=0.
